// File: rtl/goertzel_loop_engine_pkg.sv
// Shared Q-format constants, FSM encoding and saturation helper for the Goertzel loop engine.
package goertzel_loop_engine_pkg;

  localparam int GZ_D_W        = 16;
  localparam int GZ_B_W        = 8;
  localparam int GZ_FRAC       = 14;
  localparam int SAMPLE_OFFSET = 128;
  localparam int SUM_W         = 2 * GZ_D_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gz_state_t;

  function automatic logic signed [GZ_D_W-1:0] sat_d_w(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    hi = SUM_W'((1 << (GZ_D_W - 1)) - 1);
    lo = -hi - SUM_W'(1);
    if (v > hi)
      sat_d_w = hi[GZ_D_W-1:0];
    else if (v < lo)
      sat_d_w = lo[GZ_D_W-1:0];
    else
      sat_d_w = v[GZ_D_W-1:0];
  endfunction

endpackage

// File: rtl/goertzel_loop_engine_mul.sv
// Combinational signed W x W multiply; full product plus the Q2.14-aligned truncation.
module fix14_signed_mul
  import goertzel_loop_engine_pkg::*;
#(
  parameter int W    = GZ_D_W,
  parameter int FRAC = GZ_FRAC
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] product,
  output logic signed [W-1:0]   product_q
);

  assign product   = (2*W)'(a) * (2*W)'(b);
  assign product_q = product[FRAC+W-1:FRAC];

endmodule

// File: rtl/goertzel_loop_engine.sv
// Goertzel recurrence over one sample bank; returns the last two states for post-processing.
//   state   | meaning
//   ST_IDLE | ready high, waiting for start; T1/T2 hold last result
//   ST_RUN  | one sample consumed per enabled edge, down-counter tracks remaining
module goertzel_loop_engine
  import goertzel_loop_engine_pkg::*;
#(
  parameter int D_W         = GZ_D_W,
  parameter int B_W         = GZ_B_W,
  parameter int NUM_SAMPLES = 512,
  parameter int NS_BITS     = 9,
  parameter int FRAC        = GZ_FRAC
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic signed [D_W-1:0] coeff,
  input  logic [B_W-1:0]        data_n,
  output logic signed [D_W-1:0] T1,
  output logic signed [D_W-1:0] T2,
  output logic [NS_BITS-1:0]    read_address,
  output logic                  ready,
  output logic                  done
);

  gz_state_t               state;
  logic signed [D_W-1:0]   s1;
  logic signed [D_W-1:0]   s2;
  logic signed [D_W-1:0]   coeff_q;
  logic [NS_BITS-1:0]      cnt;

  logic signed [2*D_W-1:0] prod;
  logic signed [D_W-1:0]   prod_q;
  logic signed [SUM_W-1:0] x_ext;
  logic signed [SUM_W-1:0] sum;
  logic signed [D_W-1:0]   s_new;

  fix14_signed_mul #(.W(D_W), .FRAC(FRAC)) u_mul (
    .a         (coeff_q),
    .b         (s1),
    .product   (prod),
    .product_q (prod_q)
  );

  // Sum kept at full product width so the clamp sees the true value before narrowing.
  assign x_ext = SUM_W'($signed({1'b0, data_n})) - SUM_W'(SAMPLE_OFFSET);
  assign sum   = (prod >>> FRAC) + x_ext - SUM_W'(s2);
  assign s_new = sat_d_w(sum);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      done         <= 1'b0;
      T1           <= '0;
      T2           <= '0;
      read_address <= '0;
      s1           <= '0;
      s2           <= '0;
      coeff_q      <= '0;
      cnt          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            s1           <= '0;
            s2           <= '0;
            read_address <= '0;
            ready        <= 1'b0;
            coeff_q      <= coeff;
            cnt          <= NS_BITS'(NUM_SAMPLES - 1);
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (enable) begin
            s2           <= s1;
            s1           <= s_new;
            read_address <= read_address + NS_BITS'(1);
            cnt          <= cnt - NS_BITS'(1);
            if (cnt == '0) begin
              T1           <= s_new;
              T2           <= s1;
              done         <= 1'b1;
              ready        <= 1'b1;
              read_address <= '0;
              state        <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_loop_engine.sv
// Directed bench for goertzel_loop_engine with a falling-edge sample RAM model.
module tb_goertzel_loop_engine;

  logic               sys_clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               start;
  logic signed [15:0] coeff;
  logic [7:0]         data_n = 8'd128;
  logic signed [15:0] T1;
  logic signed [15:0] T2;
  logic [8:0]         read_address;
  logic               ready;
  logic               done;

  logic [7:0] mem [0:511];
  int n_checks = 0;
  int n_errors = 0;
  int hold_checks = 0;

  goertzel_loop_engine dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .start        (start),
    .coeff        (coeff),
    .data_n       (data_n),
    .T1           (T1),
    .T2           (T2),
    .read_address (read_address),
    .ready        (ready),
    .done         (done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) data_n <= mem[read_address];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic fill(input logic [7:0] val);
    for (int i = 0; i < 512; i++) mem[i] = val;
  endtask

  task automatic start_pulse(input logic [15:0] c);
    @(posedge sys_clk); #1;
    start = 1'b1;
    coeff = c;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int cyc, output int en_edges, output int addr_bad);
    bit         got;
    bit         prev_en;
    logic [8:0] prev_addr;
    logic [8:0] exp_addr;
    cyc = 0; en_edges = 0; addr_bad = 0; got = 1'b0;
    while (!got && cyc < 3000) begin
      prev_en   = enable;
      prev_addr = read_address;
      @(posedge sys_clk); #1;
      cyc++;
      if (prev_en) en_edges++;
      if (toggle) begin
        if (!prev_en && !done && hold_checks < 4) begin
          check("addr_hold", 16'(read_address), 16'(prev_addr));
          hold_checks++;
        end
        enable = ~enable;
      end else begin
        exp_addr = cyc[8:0];
        if (read_address !== exp_addr) addr_bad++;
      end
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 16'd0, 16'd1);
    enable = 1'b1;
  endtask

  int cyc;
  int en_edges;
  int addr_bad;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    start  = 1'b0;
    coeff  = 16'sd0;
    fill(8'd128);
    #23;
    check("rst_ready", 16'(ready), 16'd1);
    check("rst_done", 16'(done), 16'd0);
    check("rst_T1", T1, 16'd0);
    check("rst_T2", T2, 16'd0);
    check("rst_addr", 16'(read_address), 16'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // x=1, coeff=1.0: period-6 sequence 1,2,2,1,0,0
    fill(8'd129);
    start_pulse(16'h4000);
    check("busy_ready", 16'(ready), 16'd0);
    wait_done(1'b0, cyc, en_edges, addr_bad);
    check("x1_latency", 16'(cyc), 16'd512);
    check("x1_addr_seq", 16'(addr_bad), 16'd0);
    check("x1_T1", T1, 16'd2);
    check("x1_T2", T2, 16'd1);
    check("x1_ready", 16'(ready), 16'd1);
    @(posedge sys_clk); #1;
    check("x1_done_single", 16'(done), 16'd0);

    fill(8'd128);
    start_pulse(16'h4000);
    wait_done(1'b0, cyc, en_edges, addr_bad);
    check("x0_latency", 16'(cyc), 16'd512);
    check("x0_addr_seq", 16'(addr_bad), 16'd0);
    check("x0_T1", T1, 16'd0);
    check("x0_T2", T2, 16'd0);

    fill(8'd255);
    start_pulse(16'h7FFF);
    wait_done(1'b0, cyc, en_edges, addr_bad);
    check("sat_T1", T1, 16'h7FFF);
    check("sat_T2", T2, 16'h7FFF);

    fill(8'd127);
    start_pulse(16'h4000);
    wait_done(1'b0, cyc, en_edges, addr_bad);
    check("neg_T1", T1, 16'hFFFE);
    check("neg_T2", T2, 16'hFFFF);

    // coeff=0: impulse at address 510 lands only in s[510]
    fill(8'd128);
    mem[510] = 8'd129;
    start_pulse(16'h0000);
    wait_done(1'b0, cyc, en_edges, addr_bad);
    check("imp_T1", T1, 16'd0);
    check("imp_T2", T2, 16'd1);

    fill(8'd128);
    start_pulse(16'h4000);
    wait_done(1'b0, cyc, en_edges, addr_bad);
    fill(8'd129);
    start_pulse(16'h4000);
    wait_done(1'b1, cyc, en_edges, addr_bad);
    check("tog_en_edges", 16'(en_edges), 16'd512);
    check("tog_cycles", 16'(cyc), 16'd1023);
    check("tog_T1", T1, 16'd2);
    check("tog_T2", T2, 16'd1);

    // second start mid-run with a different coeff must be ignored
    fill(8'd128);
    start_pulse(16'h4000);
    wait_done(1'b0, cyc, en_edges, addr_bad);
    fill(8'd129);
    start_pulse(16'h4000);
    repeat (200) @(posedge sys_clk);
    #1;
    start = 1'b1;
    coeff = 16'h0000;
    @(posedge sys_clk); #1;
    start = 1'b0;
    wait_done(1'b0, cyc, en_edges, addr_bad);
    check("midstart_latency", 16'(cyc), 16'd311);
    check("midstart_T1", T1, 16'd2);
    check("midstart_T2", T2, 16'd1);

    // start held across the done edge must not relaunch
    start_pulse(16'h4000);
    repeat (511) @(posedge sys_clk);
    #1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    check("rerun_done", 16'(done), 16'd1);
    check("rerun_T1", T1, 16'd2);
    check("rerun_T2", T2, 16'd1);
    start = 1'b0;
    @(posedge sys_clk); #1;
    check("done_edge_start_ignored", 16'(ready), 16'd1);
    check("rerun_done_single", 16'(done), 16'd0);

    start_pulse(16'h4000);
    repeat (100) @(posedge sys_clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 16'(ready), 16'd1);
    check("abort_done", 16'(done), 16'd0);
    check("abort_T1", T1, 16'd0);
    check("abort_T2", T2, 16'd0);
    check("abort_addr", 16'(read_address), 16'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("abort_no_done", 16'(done), 16'd0);

    start_pulse(16'h4000);
    wait_done(1'b0, cyc, en_edges, addr_bad);
    check("post_abort_latency", 16'(cyc), 16'd512);
    check("post_abort_T1", T1, 16'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
